// File: rtl/ramb_pkg.sv
// Shared types and RAM geometry for the RAM block arbiter (SB_RAM40_4K, 256x16 mode).
package ramb_pkg;

  localparam int unsigned RAM_ADDR_W = 11;
  localparam int unsigned RAM_DATA_W = 16;

  typedef enum logic {
    ST_CLEAR,
    ST_SERVE
  } state_t;

  // Last-grant pointer encoding: PTR_A means A was granted last, so B wins a tie.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants the lone requester, or on contention the
// requester that was not granted last (ptr_i = last granted, 0 = A, 1 = B).
module rr_arb2 (
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_i ? 2'b01 : 2'b10;
        default: gnt_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/ramb_arbiter.sv
// Two-requester arbiter in front of one SB_RAM40_4K (mode 0, 256x16), read latency 1.
// Optional post-reset zero sweep of the RAM is enabled by defining RAMB_ARB_CLEAR_EN.
module ramb_arbiter
  import ramb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  CLKIN,
  input  logic                  RESETN,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADDR_W-1:0]     A_ADDR,
  input  logic [DATA_W-1:0]     A_WDATA,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADDR_W-1:0]     B_ADDR,
  input  logic [DATA_W-1:0]     B_WDATA,
  output logic                  A_GNT,
  output logic                  B_GNT,
  output logic                  A_RVALID,
  output logic                  B_RVALID,
  output logic [DATA_W-1:0]     RDATA,
  output logic                  BUSY,
  output logic [RAM_ADDR_W-1:0] RAM_RADDR,
  output logic [RAM_ADDR_W-1:0] RAM_WADDR,
  output logic                  RAM_RE,
  output logic                  RAM_WE,
  output logic [RAM_DATA_W-1:0] RAM_WDATA,
  output logic [RAM_DATA_W-1:0] RAM_MASK,
  input  logic [RAM_DATA_W-1:0] RAM_RDATA
);

  state_t            state_q;
  logic              clear_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef RAMB_ARB_CLEAR_EN
  state_t            state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] clr_cnt_d;

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) begin
        state_d = ST_SERVE;
      end
    end
  end

  // Reset gates the sweep write so nothing reaches the RAM while RESETN is low.
  assign clear_we = (state_q == ST_CLEAR) && RESETN;
  assign clr_addr = clr_cnt_q;
`else
  assign state_q  = ST_SERVE;
  assign clear_we = 1'b0;
  assign clr_addr = '0;
`endif

  logic              serve;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              ptr_q;
  logic              ptr_d;
  logic              rvalid_a_q;
  logic              rvalid_b_q;

  assign BUSY  = (state_q == ST_CLEAR);
  assign serve = RESETN && (state_q == ST_SERVE);

  rr_arb2 u_arb (
    .en_i  (serve),
    .req_i ({B_REQ, A_REQ}),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    any_gnt   = |gnt;
    sel_we    = gnt[1] ? B_WE    : A_WE;
    sel_addr  = gnt[1] ? B_ADDR  : A_ADDR;
    sel_wdata = gnt[1] ? B_WDATA : A_WDATA;
    ptr_d     = ptr_q;
    if (any_gnt) begin
      ptr_d = gnt[1] ? PTR_B : PTR_A;
    end
    waddr = sel_addr;
    wdata = sel_wdata;
    if (clear_we) begin
      waddr = clr_addr;
      wdata = '0;
    end
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      ptr_q      <= PTR_A;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rvalid_a_q <= gnt[0] && !A_WE;
      rvalid_b_q <= gnt[1] && !B_WE;
    end
  end

  assign A_GNT     = gnt[0];
  assign B_GNT     = gnt[1];
  assign A_RVALID  = rvalid_a_q;
  assign B_RVALID  = rvalid_b_q;
  assign RDATA     = DATA_W'(RAM_RDATA);

  assign RAM_WE    = (any_gnt && sel_we) || clear_we;
  assign RAM_RE    = any_gnt && !sel_we;
  assign RAM_WADDR = {{(RAM_ADDR_W - ADDR_W){1'b0}}, waddr};
  assign RAM_RADDR = {{(RAM_ADDR_W - ADDR_W){1'b0}}, sel_addr};
  assign RAM_WDATA = RAM_DATA_W'(wdata);
  assign RAM_MASK  = '0;

endmodule

// File: doc/ramb_arbiter.md
RAMB_ARBITER -- requirements
Module: ramb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, requester word-address width (256 x 16 RAM mode).
REQ-002 SHALL have parameter DATA_W, default 16, requester and RAM data width.
REQ-003 SHALL have port CLKIN  in  1  single clock for all logic and RAM RCLK/WCLK; one clock only.
REQ-004 SHALL have port RESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports A_REQ/B_REQ  in  1  requester access request, held until granted.
REQ-006 SHALL have ports A_WE/B_WE  in  1  1 = write, 0 = read.
REQ-007 SHALL have ports A_ADDR/B_ADDR  in  ADDR_W  word address.
REQ-008 SHALL have ports A_WDATA/B_WDATA  in  DATA_W  write data.
REQ-009 SHALL have ports A_GNT/B_GNT  out  1  access accepted this cycle, combinational.
REQ-010 SHALL have ports A_RVALID/B_RVALID  out  1  RDATA holds this requester's read result.
REQ-011 SHALL have port RDATA  out  DATA_W  RAM read data, passed through from RAM_RDATA.
REQ-012 SHALL have port BUSY  out  1  block not accepting requests.
REQ-013 SHALL have RAM-side ports RAM_RADDR/RAM_WADDR out 11, RAM_RE/RAM_WE out 1, RAM_WDATA out 16, RAM_MASK out 16, and RAM_RDATA in 16.

Function
REQ-014 SHALL drive the upper 11-ADDR_W bits of RAM_RADDR/RAM_WADDR and all RAM_MASK bits to 0.
REQ-015 SHALL implement FSM states CLEAR and SERVE; CLEAR exists only per REQ-027.
REQ-016 SHALL, in SERVE, grant at most one requester per cycle: a single requester gets the grant; with both requesting, the one not granted last gets it.
REQ-017 SHALL update the last-grant pointer only on a cycle with a grant.
REQ-018 SHALL, for a granted write, drive RAM_WE=1, RAM_WADDR=addr and RAM_WDATA=wdata combinationally in the grant cycle; the write completes at that CLKIN edge.
REQ-019 SHALL, for a granted read, drive RAM_RE=1 and RAM_RADDR=addr in the grant cycle.
REQ-020 SHALL assert the granted requester's RVALID for exactly the next cycle, with RDATA valid alongside it (read latency 1).
REQ-021 SHALL hold RAM_WE=0 and RAM_RE=0 in cycles without a grant.
REQ-022 SHALL return read-before-write data for a read granted in cycle N followed by a write to the same address in cycle N+1.
REQ-023 SHALL allow back-to-back grants every cycle with no bubble, including an alternating A/B pattern.
REQ-024 SHALL hold GNT=0 whenever BUSY=1, regardless of REQ.

Reset
REQ-025 SHALL, on RESETN low: GNT=0, RVALID=0, pointer=A (B wins first contention), RAM_WE=0, RAM_RE=0, clear counter=0; FSM to CLEAR if RAMB_ARB_CLEAR_EN is defined, else SERVE.
REQ-026 SHALL abort any clear sweep or in-flight read when reset asserts mid-operation; no RVALID is asserted after reset release for a read granted before reset.

Configuration
REQ-027 SHALL, with RAMB_ARB_CLEAR_EN defined, run CLEAR after reset: BUSY=1 and RAM_WE=1 with RAM_WDATA=0 at addresses 0..2^ADDR_W-1, one per cycle, then move to SERVE with BUSY=0 on the cycle after address 2^ADDR_W-1.
REQ-028 SHALL, without RAMB_ARB_CLEAR_EN, contain no clear logic, tie BUSY=0, and serve requests from the first cycle after reset release.

Structure
REQ-029 SHALL place the FSM state enum, the RAM address width (11) and the RAM data width (16) in shared package ramb_pkg.
REQ-030 SHALL implement arbitration in sub-module rr_arb2 (2-way round-robin: req[1:0], pointer, gnt[1:0]); the FSM, clear counter and RAM muxing stay in ramb_arbiter.
REQ-031 SHALL not instantiate SB_RAM40_4K; the parent connects the RAM in mode 0 (256x16).

Verification
REQ-032 SHALL cover: CLEAR_EN defined, reset release -> BUSY=1 for 256 cycles, RAM_WE=1 at addresses 0x00..0xFF with data 0, then BUSY=0; a read of 0x55 returns 0x0000.
REQ-033 SHALL cover: A writes 0x1234 at 0x10, then A reads 0x10 -> A_RVALID=1 exactly one cycle after the grant, RDATA=0x1234, B_RVALID=0.
REQ-034 SHALL cover: A and B both request continuously for 6 cycles after reset -> grants B,A,B,A,B,A.
REQ-035 SHALL cover: B reads 0x20 (holds 0xAAAA) in cycle N, A writes 0x5555 to 0x20 in cycle N+1 -> B_RVALID with RDATA=0xAAAA.
REQ-036 SHALL cover: RESETN pulsed low at clear address 0x80 -> sweep restarts at 0x00; a read granted one cycle before reset yields no RVALID.
REQ-037 SHALL cover: CLEAR_EN undefined -> BUSY=0 always; a REQ in the first cycle after reset release is granted that cycle.
